// File: rtl/linked_list_drain.sv
// Drains a shared linked-list FIFO round-robin across its logical queues into a 2-entry in-order output buffer.
// Latency: the pop strobe and its capture share one edge; a word popped into an empty buffer is presented the next cycle.
// Backpressure: out_valid/out_ready handshake; pop stalls only when both buffer slots are full and nothing drains this cycle.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   fifo_empty         per-queue empty flags from the shared FIFO
//   fifo_data          head word of the queue addressed by pop_sel (same-cycle)
//   pop, pop_sel       pop strobe and selected queue index
//   out_valid/ready    downstream handshake
//   out_data, out_sel  oldest buffered word and its source queue (zero when the buffer is empty)
//   pop_count          pops since reset, modulo 256
module linked_list_drain #(
    parameter int WIDTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic [7:0]           pop_count
);

    typedef struct packed {
        logic [SEL_WIDTH-1:0] sel;
        logic [WIDTH-1:0]     data;
    } entry_t;

    // slot0 is always the head; slot1 is only meaningful when occ == 2.
    entry_t               slot0;
    entry_t               slot1;
    logic [1:0]           occ;
    logic [SEL_WIDTH-1:0] rr_ptr;

    logic                   any_nonempty;
    logic                   deq;
    logic                   enq;
    logic [SEL_WIDTH-1:0]   rr_next;
    entry_t                 new_entry;
    logic [2*NUM_FIFOS-1:0] nonempty_x2;
    logic [2*NUM_FIFOS-1:0] rotated;
    int                     first_off;
    int                     sel_sum;

    // Round-robin pick: duplicate the non-empty mask and shift it down by
    // rr_ptr so bit k of the result is queue (rr_ptr + k) mod NUM_FIFOS.
    // The lowest set bit is the winner; with nothing set the offset stays 0,
    // which leaves pop_sel parked on rr_ptr.
    always_comb begin
        nonempty_x2 = {~fifo_empty, ~fifo_empty};
        rotated     = nonempty_x2 >> rr_ptr;
        first_off   = 0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first_off = i;
            end
        end
        sel_sum = int'(rr_ptr) + first_off;
        if (sel_sum >= NUM_FIFOS) begin
            sel_sum = sel_sum - NUM_FIFOS;
        end
        pop_sel = SEL_WIDTH'(sel_sum);
    end

    always_comb begin
        if (int'(pop_sel) == NUM_FIFOS - 1) begin
            rr_next = '0;
        end else begin
            rr_next = pop_sel + SEL_WIDTH'(1);
        end
    end

    assign any_nonempty = ~(&fifo_empty);
    assign out_valid    = (occ != 2'd0);
    assign deq          = out_valid & out_ready;

    // A full buffer can still accept a pop when the head leaves in the same
    // cycle; this is what sustains one pop per cycle with out_ready high.
    assign pop = ~rst & any_nonempty & ((occ != 2'd2) | deq);
    assign enq = pop;

    assign new_entry.sel  = pop_sel;
    assign new_entry.data = fifo_data;

    // Mask the head so the outputs read zero whenever nothing is buffered.
    assign out_data = out_valid ? slot0.data : '0;
    assign out_sel  = out_valid ? slot0.sel  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            slot0     <= '0;
            slot1     <= '0;
            rr_ptr    <= '0;
            pop_count <= 8'd0;
        end else begin
            if (pop) begin
                rr_ptr    <= rr_next;
                pop_count <= pop_count + 8'd1;
            end

            case ({enq, deq})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= new_entry;
                    end else begin
                        slot1 <= new_entry;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    slot1 <= '0;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // survives the dequeue so order is preserved.
                    if (occ == 2'd1) begin
                        slot0 <= new_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linked_list_drain.sv
// Bench for linked_list_drain: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_linked_list_drain;

    localparam int N = 2;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] fifo_empty;
    logic [W-1:0] fifo_data;
    logic         pop;
    logic [0:0]   pop_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [0:0]   out_sel;
    logic [7:0]   pop_count;

    linked_list_drain #(
        .WIDTH    (W),
        .NUM_FIFOS(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .pop       (pop),
        .pop_sel   (pop_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .pop_count (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: FIFO of buffered words, round-robin pointer, pop count.
    typedef struct {
        int         sel;
        logic [3:0] data;
    } ent_t;

    ent_t m_q[$];
    int   m_rr  = 0;
    int   m_cnt = 0;

    typedef struct {
        logic       r;
        logic [1:0] e;
        logic [3:0] d;
        logic       rd;
        logic       pop;
        logic       psel;
        logic       vld;
        logic [3:0] od;
        logic       os;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic r, input logic [1:0] e, input logic [3:0] d,
                                input logic rd, input logic p, input logic ps, input logic v,
                                input logic [3:0] od, input logic os, input logic [7:0] cnt);
        vec_t t;
        t.r = r; t.e = e; t.d = d; t.rd = rd;
        t.pop = p; t.psel = ps; t.vld = v; t.od = od; t.os = os; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] e, input logic [3:0] d, input logic rd);
        rst        = r;
        fifo_empty = e;
        fifo_data  = d;
        out_ready  = rd;
    endtask

    function automatic logic m_pop();
        return !rst && (fifo_empty != 2'b11) &&
               (m_q.size() < 2 || (m_q.size() != 0 && out_ready));
    endfunction

    function automatic int m_sel();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!fifo_empty[j]) return j;
        end
        return m_rr;
    endfunction

    task automatic check_model();
        chk("pop", pop, m_pop());
        chk("pop_sel", pop_sel, m_sel());
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("out_data", out_data, (m_q.size() != 0) ? m_q[0].data : 4'h0);
        chk("out_sel", out_sel, (m_q.size() != 0) ? m_q[0].sel : 0);
        chk("pop_count", pop_count, m_cnt);
    endtask

    // Advance the model with the inputs of this cycle, then cross the edge.
    task automatic finish_cycle();
        logic p;
        int   s;
        ent_t e;
        p = m_pop();
        s = m_sel();
        if (pop === 1'b1) begin
            chk("pop_to_nonempty", fifo_empty[pop_sel], 1'b0);
        end
        if (rst) begin
            m_q.delete();
            m_rr  = 0;
            m_cnt = 0;
        end else begin
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (p) begin
                e.sel  = s;
                e.data = fifo_data;
                m_q.push_back(e);
                m_rr  = (s + 1) % N;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_cycle();
        @(negedge clk);
        check_model();
        finish_cycle();
    endtask

    int npops;

    initial begin
        // Reset, all empty, ready high.
        for (int i = 0; i < 5; i++) tbl[i] = mk(0, 2'b11, 4'h0, 1, 0, 0, 0, 4'h0, 0, 8'd0);
        // Both queues busy: alternating pops, one-cycle pop-to-output.
        tbl[5]  = mk(0, 2'b00, 4'hA, 1, 1, 0, 0, 4'h0, 0, 8'd0);
        tbl[6]  = mk(0, 2'b00, 4'hA, 1, 1, 1, 1, 4'hA, 0, 8'd1);
        tbl[7]  = mk(0, 2'b00, 4'hA, 1, 1, 0, 1, 4'hA, 1, 8'd2);
        tbl[8]  = mk(0, 2'b00, 4'hA, 1, 1, 1, 1, 4'hA, 0, 8'd3);
        tbl[9]  = mk(0, 2'b11, 4'h0, 1, 0, 0, 1, 4'hA, 1, 8'd4);
        tbl[10] = mk(0, 2'b11, 4'h0, 1, 0, 0, 0, 4'h0, 0, 8'd4);
        // Queue 0 only, downstream stalled: two pops fill the buffer, then hold.
        tbl[11] = mk(0, 2'b10, 4'h3, 0, 1, 0, 0, 4'h0, 0, 8'd4);
        tbl[12] = mk(0, 2'b10, 4'h5, 0, 1, 0, 1, 4'h3, 0, 8'd5);
        tbl[13] = mk(0, 2'b10, 4'h7, 0, 0, 0, 1, 4'h3, 0, 8'd6);
        tbl[14] = mk(0, 2'b10, 4'h7, 0, 0, 0, 1, 4'h3, 0, 8'd6);
        // Full buffer with drain: pop in the same cycle, order kept.
        tbl[15] = mk(0, 2'b00, 4'h9, 1, 1, 1, 1, 4'h3, 0, 8'd6);
        tbl[16] = mk(0, 2'b00, 4'hB, 0, 0, 0, 1, 4'h5, 0, 8'd7);
        // Reset while full, then restart scanning from queue 0.
        tbl[17] = mk(1, 2'b00, 4'hC, 0, 0, 0, 1, 4'h5, 0, 8'd7);
        tbl[18] = mk(0, 2'b00, 4'hD, 1, 1, 0, 0, 4'h0, 0, 8'd0);
        tbl[19] = mk(0, 2'b11, 4'h0, 1, 0, 1, 1, 4'hD, 0, 8'd1);
        tbl[20] = mk(0, 2'b11, 4'h0, 0, 0, 1, 0, 4'h0, 0, 8'd1);

        drive(1, 2'b11, 4'h0, 1);
        @(posedge clk);
        #1;
        m_q.delete();
        m_rr  = 0;
        m_cnt = 0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].rd);
            @(negedge clk);
            chk($sformatf("vec%0d_pop", i), pop, tbl[i].pop);
            chk($sformatf("vec%0d_pop_sel", i), pop_sel, tbl[i].psel);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].vld);
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("vec%0d_out_sel", i), out_sel, tbl[i].os);
            chk($sformatf("vec%0d_pop_count", i), pop_count, tbl[i].cnt);
            finish_cycle();
        end

        // 300 back-to-back pops with ready held high.
        drive(1, 2'b11, 4'h0, 1);
        model_cycle();
        npops = 0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 2'($urandom_range(0, 2)), 4'($urandom), 1);
            @(negedge clk);
            check_model();
            if (pop === 1'b1) npops++;
            finish_cycle();
        end
        chk("pops_in_300", npops, 300);
        chk("pop_count_300", pop_count, 44);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
